gpio_serial_loader: RTL and testbench
=====================================

# gpio_serial_loader

Serial configuration transmitter for the user-project GPIO pad array. On request, it reads one 13-bit configuration word per pad from the housekeeping configuration registers and shifts the words MSB-first into the pad-control daisy chain. After the last bit it pulses the chain latch, so every pad's `dm`, `oeb`, `inp_dis`, `vtrip_sel`, `slow_sel`, `holdover`, `analog_*` and `ib_mode_sel` controls update together. The block sits in housekeeping and drives the head of the control-block chain that feeds the pad array.

## Interface
Parameters:
- `TOTAL_PADS`, default `MPRJ_IO_PADS` (38): number of pads, which is also the number of words shifted.
- `CLK_DIV`, default 2: `wb_clk_i` cycles per `serial_clock` half-period. Must be at least 1.

Ports:
- `wb_clk_i`  in  1  block clock.
- `wb_rstn_i`  in  1  reset. Synchronous, active-low.
- `start`  in  1  single-cycle request to begin a full chain load.
- `busy`  out  1  high while a load is in progress.
- `done`  out  1  single-cycle pulse when the latch phase completes.
- `cfg_rd_idx`  out  clog2(TOTAL_PADS)  pad index being fetched.
- `cfg_rd_data`  in  13  configuration word for `cfg_rd_idx`. Combinational read that must be valid in the same cycle.
- `serial_clock`  out  1  chain shift clock.
- `serial_data_out`  out  1  chain data. Changes only while `serial_clock` is low.
- `serial_load`  out  1  chain latch strobe.

## Operation
- Config word layout:
  - bit0: mgmt_ena
  - bit1: outenb
  - bit2: holdover
  - bit3: inp_dis
  - bit4: ib_mode_sel
  - bit5: analog_en
  - bit6: analog_sel
  - bit7: analog_pol
  - bit8: slow_sel
  - bit9: vtrip_sel
  - bits12:10: dm[2:0]
- Pad order: the first word shifted lands in the farthest pad. Words are therefore sent from pad `TOTAL_PADS-1` down to pad 0, each MSB (bit12) first.
- FSM states: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH_HI, LATCH_LO, DONE.
- IDLE:
  - `start` high moves to FETCH, with `cfg_rd_idx` = `TOTAL_PADS-1`.
  - `start` is ignored in every other state.
- FETCH (1 cycle): `cfg_rd_data` is captured into a 13-bit shift register. The bit counter loads 12. Next state is SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles): `serial_clock`=0 and `serial_data_out` = shift register MSB. Next state is SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles): `serial_clock`=1 and data is held. On exit the shift register shifts left and the bit counter decrements. Exit goes to:
  - SHIFT_LO if bits remain;
  - FETCH with `cfg_rd_idx`-1 if pads remain;
  - LATCH_HI otherwise.
- LATCH_HI (CLK_DIV cycles): `serial_load`=1 and `serial_clock`=0.
- LATCH_LO (CLK_DIV cycles): `serial_load`=0.
- DONE (1 cycle): `done`=1 and `busy`=0, then IDLE.
- Reset values, which also apply in IDLE:
  - `busy`, `done`, `serial_clock`, `serial_data_out`, `serial_load` = 0.
  - `cfg_rd_idx` = 0.
  - State is IDLE and all counters are 0.
- Reset mid-operation: all outputs return to their reset values on the next edge. `serial_load` is never pulsed, so the pads keep their previous latched configuration.
- Counters:
  - divide counter is clog2(CLK_DIV+1) bits and counts down;
  - bit counter is 4 bits;
  - pad index wraps at no point, because termination is detected at index 0.

## Timing
- `start` is sampled at edge k. From k+1: `busy`=1 and state is FETCH.
- Per pad: 1 + 2·CLK_DIV·13 cycles.
- `done` is high for exactly one cycle, beginning 1 + TOTAL_PADS·(1+26·CLK_DIV) + 2·CLK_DIV cycles after edge k.
- `busy` falls in the same cycle `done` rises.
- A `start` asserted during the DONE cycle is ignored. A `start` in the following IDLE cycle is accepted.
- All outputs are registered. There is no combinational path from `start` or `cfg_rd_data` to any output.
- Data setup to the `serial_clock` rising edge is CLK_DIV cycles. Data hold after it is CLK_DIV cycles.

## Structure
- Package `gpio_cfg_pkg` holds:
  - `CFG_BITS` = 13;
  - the field offset constants (`CFG_MGMT_ENA` … `CFG_DM_LSB`=10);
  - the FSM state enum `gpio_ldr_state_t`.
- One sub-module, `gpio_serial_clkdiv`: a CLK_DIV phase counter with reload and a terminal-count `tick` output. It is shared by the SHIFT and LATCH states.

## Test plan
- Reset: hold `wb_rstn_i`=0 for 3 cycles, then release. All outputs are 0, `busy`=0, and there is no `serial_clock` toggle without `start`.
- Load with TOTAL_PADS=2, CLK_DIV=1, and words pad1=0x1803, pad0=0x0402:
  - bits sampled at `serial_clock` rising edges are 1100000000011 then 0010000000010;
  - exactly one `serial_load` pulse, 1 cycle wide;
  - `done` appears 57 cycles after the `start` edge.
- Pulse `start` repeatedly while `busy`: exactly 26 rising edges per run (TOTAL_PADS=2) and one `done`.
- Assert `wb_rstn_i`=0 during pad 1, bit 5: next cycle all outputs are 0, `serial_load` is never asserted, and a fresh `start` completes a normal full load.
- Back-to-back: `start` in the cycle after `done` is accepted; `start` coincident with `done` is dropped.
- CLK_DIV=3, TOTAL_PADS=38, all words 0x1FFF:
  - `serial_clock` low 3 / high 3 cycles;
  - 494 rising edges;
  - `done` at 1+38·79+6 = 3009 cycles.

Source files
------------

// File: rtl/gpio_cfg_pkg.sv
// Shared constants, config-word field offsets and FSM states for the GPIO
// pad-control serial loader.
package gpio_cfg_pkg;

    localparam int unsigned MPRJ_IO_PADS = 38;
    localparam int unsigned CFG_BITS     = 13;

    localparam int unsigned CFG_MGMT_ENA    = 0;
    localparam int unsigned CFG_OUTENB      = 1;
    localparam int unsigned CFG_HOLDOVER    = 2;
    localparam int unsigned CFG_INP_DIS     = 3;
    localparam int unsigned CFG_IB_MODE_SEL = 4;
    localparam int unsigned CFG_ANALOG_EN   = 5;
    localparam int unsigned CFG_ANALOG_SEL  = 6;
    localparam int unsigned CFG_ANALOG_POL  = 7;
    localparam int unsigned CFG_SLOW_SEL    = 8;
    localparam int unsigned CFG_VTRIP_SEL   = 9;
    localparam int unsigned CFG_DM_LSB      = 10;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShiftLo,
        StShiftHi,
        StLatchHi,
        StLatchLo,
        StDone
    } gpio_ldr_state_t;

    // Packs individual pad controls into one chain word.
    function automatic logic [CFG_BITS-1:0] cfg_word(
        input logic [2:0] dm,
        input logic       vtrip_sel,
        input logic       slow_sel,
        input logic       analog_pol,
        input logic       analog_sel,
        input logic       analog_en,
        input logic       ib_mode_sel,
        input logic       inp_dis,
        input logic       holdover,
        input logic       outenb,
        input logic       mgmt_ena
    );
        logic [CFG_BITS-1:0] w;
        w                   = '0;
        w[CFG_MGMT_ENA]     = mgmt_ena;
        w[CFG_OUTENB]       = outenb;
        w[CFG_HOLDOVER]     = holdover;
        w[CFG_INP_DIS]      = inp_dis;
        w[CFG_IB_MODE_SEL]  = ib_mode_sel;
        w[CFG_ANALOG_EN]    = analog_en;
        w[CFG_ANALOG_SEL]   = analog_sel;
        w[CFG_ANALOG_POL]   = analog_pol;
        w[CFG_SLOW_SEL]     = slow_sel;
        w[CFG_VTRIP_SEL]    = vtrip_sel;
        w[CFG_DM_LSB +: 3]  = dm;
        return w;
    endfunction

endpackage

// File: rtl/gpio_serial_clkdiv.sv
// Down-counting phase timer: reload starts a CLK_DIV-cycle phase, tick marks
// its last cycle.
module gpio_serial_clkdiv #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_reload,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (i_reload) begin
            r_cnt <= CNT_W'(CLK_DIV - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts one configuration word per pad, farthest pad first and MSB first,
// into the pad-control daisy chain, then strobes the chain latch.
module gpio_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int unsigned  TOTAL_PADS = MPRJ_IO_PADS,
    parameter int unsigned  CLK_DIV    = 2,
    localparam int unsigned IDX_W      = (TOTAL_PADS > 1) ? $clog2(TOTAL_PADS) : 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    cfg_rd_idx,
    input  logic [CFG_BITS-1:0] cfg_rd_data,
    output logic                serial_clock,
    output logic                serial_data_out,
    output logic                serial_load
);

    gpio_ldr_state_t     r_state;
    logic                r_start;
    logic [CFG_BITS-1:0] r_shift;
    logic [3:0]          r_bit_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_sclk;
    logic                r_load;
    logic                w_tick;
    logic                w_reload;

    gpio_serial_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .i_clk    (wb_clk_i),
        .i_rstn   (wb_rstn_i),
        .i_reload (w_reload),
        .o_tick   (w_tick)
    );

    // Every timed phase re-arms the divider on the cycle it hands over.
    always_comb begin
        w_reload = 1'b0;
        unique case (r_state)
            StFetch:                         w_reload = 1'b1;
            StShiftLo, StShiftHi, StLatchHi: w_reload = w_tick;
            default:                         w_reload = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            r_state   <= StIdle;
            r_start   <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_load    <= 1'b0;
        end else begin
            // Requests are only taken while idle; one captured request per run.
            r_start <= start && (r_state == StIdle) && !r_start;
            unique case (r_state)
                StIdle: begin
                    if (r_start) begin
                        r_state <= StFetch;
                        r_busy  <= 1'b1;
                        r_idx   <= IDX_W'(TOTAL_PADS - 1);
                    end
                end
                StFetch: begin
                    r_shift   <= cfg_rd_data;
                    r_bit_cnt <= 4'(CFG_BITS - 1);
                    r_state   <= StShiftLo;
                end
                StShiftLo: begin
                    if (w_tick) begin
                        r_sclk  <= 1'b1;
                        r_state <= StShiftHi;
                    end
                end
                StShiftHi: begin
                    if (w_tick) begin
                        r_sclk  <= 1'b0;
                        r_shift <= {r_shift[CFG_BITS-2:0], 1'b0};
                        if (r_bit_cnt != '0) begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                            r_state   <= StShiftLo;
                        end else if (r_idx != '0) begin
                            r_idx   <= r_idx - 1'b1;
                            r_state <= StFetch;
                        end else begin
                            r_load  <= 1'b1;
                            r_state <= StLatchHi;
                        end
                    end
                end
                StLatchHi: begin
                    if (w_tick) begin
                        r_load  <= 1'b0;
                        r_state <= StLatchLo;
                    end
                end
                StLatchLo: begin
                    if (w_tick) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign cfg_rd_idx      = r_idx;
    assign serial_clock    = r_sclk;
    assign serial_data_out = r_shift[CFG_BITS-1];
    assign serial_load     = r_load;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench: a 2-pad / CLK_DIV=1 loader for bit-level checks and a
// 38-pad / CLK_DIV=3 loader for full-length timing.
module tb_gpio_serial_loader;
    import gpio_cfg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   n_cmp = 0;
    int   n_err = 0;

    // Small instance: 2 pads, CLK_DIV=1
    logic        a_start, a_busy, a_done, a_sclk, a_sdo, a_load;
    logic [0:0]  a_idx;
    logic [12:0] a_rd_data;
    logic [12:0] a_mem [2];
    assign a_rd_data = a_mem[a_idx];

    gpio_serial_loader #(.TOTAL_PADS(2), .CLK_DIV(1)) u_dut_a (
        .wb_clk_i        (clk),
        .wb_rstn_i       (rstn),
        .start           (a_start),
        .busy            (a_busy),
        .done            (a_done),
        .cfg_rd_idx      (a_idx),
        .cfg_rd_data     (a_rd_data),
        .serial_clock    (a_sclk),
        .serial_data_out (a_sdo),
        .serial_load     (a_load)
    );

    // Full instance: 38 pads, CLK_DIV=3
    logic        b_start, b_busy, b_done, b_sclk, b_sdo, b_load;
    logic [5:0]  b_idx;
    logic [12:0] b_rd_data;

    gpio_serial_loader #(.TOTAL_PADS(38), .CLK_DIV(3)) u_dut_b (
        .wb_clk_i        (clk),
        .wb_rstn_i       (rstn),
        .start           (b_start),
        .busy            (b_busy),
        .done            (b_done),
        .cfg_rd_idx      (b_idx),
        .cfg_rd_data     (b_rd_data),
        .serial_clock    (b_sclk),
        .serial_data_out (b_sdo),
        .serial_load     (b_load)
    );

    // Chain-side observers, sampled on the falling clock edge.
    int          a_rises = 0, a_load_pulses = 0, a_load_cycles = 0, a_dones = 0, a_glitch = 0;
    logic [63:0] a_bits = '0;
    logic        a_sclk_p = 1'b0, a_sdo_p = 1'b0, a_load_p = 1'b0;

    always @(negedge clk) begin
        a_sclk_p <= a_sclk;
        a_sdo_p  <= a_sdo;
        a_load_p <= a_load;
        if (a_sclk === 1'b1 && a_sclk_p === 1'b0) begin
            a_rises <= a_rises + 1;
            a_bits  <= {a_bits[62:0], a_sdo};
        end
        if (a_sclk === 1'b1 && a_sclk_p === 1'b1 && a_sdo !== a_sdo_p) a_glitch <= a_glitch + 1;
        if (a_load === 1'b1) a_load_cycles <= a_load_cycles + 1;
        if (a_load === 1'b1 && a_load_p !== 1'b1) a_load_pulses <= a_load_pulses + 1;
        if (a_done === 1'b1) a_dones <= a_dones + 1;
    end

    int   b_rises = 0, b_zero_bits = 0, b_load_pulses = 0, b_load_cycles = 0;
    int   b_run = 0, b_hi_min = 1000, b_hi_max = 0, b_lo_min = 1000;
    logic b_sclk_p = 1'b0, b_load_p = 1'b0, b_seen_fall = 1'b0;

    always @(negedge clk) begin
        b_sclk_p <= b_sclk;
        b_load_p <= b_load;
        if (b_sclk === 1'b1 && b_sclk_p === 1'b0) begin
            b_rises <= b_rises + 1;
            if (b_sdo !== 1'b1) b_zero_bits <= b_zero_bits + 1;
        end
        if (b_sclk === b_sclk_p) begin
            b_run <= b_run + 1;
        end else begin
            b_run <= 1;
            if (b_sclk_p === 1'b1) begin
                if (b_run < b_hi_min) b_hi_min <= b_run;
                if (b_run > b_hi_max) b_hi_max <= b_run;
                b_seen_fall <= 1'b1;
            end else if (b_seen_fall && b_run < b_lo_min) begin
                b_lo_min <= b_run;
            end
        end
        if (b_load === 1'b1) b_load_cycles <= b_load_cycles + 1;
        if (b_load === 1'b1 && b_load_p !== 1'b1) b_load_pulses <= b_load_pulses + 1;
    end

    task automatic a_kick();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic b_kick();
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
    endtask

    // Edges after the start-sampling edge until done is seen; -1 on timeout.
    task automatic a_run(input int budget, output int n, output logic busy1);
        n = -1;
        busy1 = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (i == 1) busy1 = a_busy;
            if (a_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic b_run_load(input int budget, output int n, output logic busy1);
        n = -1;
        busy1 = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (i == 1) busy1 = b_busy;
            if (b_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int r0;
        int rb0;
        rstn = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        n_cmp++;
        if ({a_busy, a_done, a_sclk, a_sdo, a_load, a_idx} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs_a: got %b want 000000",
                     {a_busy, a_done, a_sclk, a_sdo, a_load, a_idx});
        end
        n_cmp++;
        if ({b_busy, b_done, b_sclk, b_sdo, b_load, b_idx} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_outputs_b: got %b want 0",
                     {b_busy, b_done, b_sclk, b_sdo, b_load, b_idx});
        end
        r0  = a_rises;
        rb0 = b_rises;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (a_rises != r0 || b_rises != rb0 || a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_quiet: rises a=%0d b=%0d busy=%b want 0 0 0",
                     a_rises - r0, b_rises - rb0, a_busy);
        end
    endtask

    task automatic test_load();
        int          r0, lp0, lc0, d0, g0, n;
        logic        busy1;
        logic [25:0] exp_bits;
        exp_bits = {13'b1100000000011, 13'b0010000000010};
        r0 = a_rises; lp0 = a_load_pulses; lc0 = a_load_cycles; d0 = a_dones; g0 = a_glitch;
        a_kick();
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL load_busy_k: got %b want 0", a_busy);
        end
        a_run(200, n, busy1);
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL load_busy_k1: got %b want 1", busy1);
        end
        n_cmp++;
        if (n != 57) begin
            n_err++;
            $display("FAIL load_done_latency: got %0d want 57", n);
        end
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL load_busy_with_done: got %b want 0", a_busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (a_done !== 1'b0) begin
            n_err++;
            $display("FAIL load_done_width: got %b want 0", a_done);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (a_rises - r0 != 26) begin
            n_err++;
            $display("FAIL load_rise_count: got %0d want 26", a_rises - r0);
        end
        n_cmp++;
        if (a_bits[25:0] !== exp_bits) begin
            n_err++;
            $display("FAIL load_bits: got %b want %b", a_bits[25:0], exp_bits);
        end
        n_cmp++;
        if (a_load_pulses - lp0 != 1 || a_load_cycles - lc0 != 1) begin
            n_err++;
            $display("FAIL load_latch_pulse: pulses %0d cycles %0d want 1 1",
                     a_load_pulses - lp0, a_load_cycles - lc0);
        end
        n_cmp++;
        if (a_dones - d0 != 1) begin
            n_err++;
            $display("FAIL load_done_count: got %0d want 1", a_dones - d0);
        end
        n_cmp++;
        if (a_glitch - g0 != 0) begin
            n_err++;
            $display("FAIL load_data_stable_high: got %0d changes want 0", a_glitch - g0);
        end
        n_cmp++;
        if (a_idx !== 1'b0) begin
            n_err++;
            $display("FAIL load_idx_idle: got %b want 0", a_idx);
        end
    endtask

    task automatic test_start_while_busy();
        int   r0, d0, lp0;
        logic seen;
        r0 = a_rises; d0 = a_dones; lp0 = a_load_pulses;
        seen = 1'b0;
        a_kick();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (a_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            a_start = ~a_start;
        end
        a_start = 1'b0;
        n_cmp++;
        if (seen !== 1'b1) begin
            n_err++;
            $display("FAIL busy_start_done_seen: got %b want 1", seen);
        end
        repeat (70) @(posedge clk);
        #1;
        n_cmp++;
        if (a_rises - r0 != 26 || a_dones - d0 != 1 || a_load_pulses - lp0 != 1) begin
            n_err++;
            $display("FAIL busy_start_single_run: rises %0d dones %0d loads %0d want 26 1 1",
                     a_rises - r0, a_dones - d0, a_load_pulses - lp0);
        end
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_start_idle_after: got %b want 0", a_busy);
        end
    endtask

    task automatic test_reset_mid();
        int          r0, lp0, n;
        logic        busy1;
        logic [25:0] exp_bits;
        exp_bits = {13'b1100000000011, 13'b0010000000010};
        r0 = a_rises; lp0 = a_load_pulses;
        a_kick();
        // After the 7th rise the line carries bit 5 of pad 1.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (a_rises - r0 == 7 && a_sclk === 1'b0) break;
        end
        n_cmp++;
        if (a_idx !== 1'b1 || a_rises - r0 != 7) begin
            n_err++;
            $display("FAIL mid_position: idx %b rises %0d want 1 7", a_idx, a_rises - r0);
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({a_busy, a_done, a_sclk, a_sdo, a_load, a_idx} !== 6'b0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %b want 000000",
                     {a_busy, a_done, a_sclk, a_sdo, a_load, a_idx});
        end
        rstn = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if (a_load_pulses != lp0 || a_rises - r0 != 7 || a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_abort_quiet: loads %0d rises %0d busy %b want 0 7 0",
                     a_load_pulses - lp0, a_rises - r0, a_busy);
        end
        r0 = a_rises; lp0 = a_load_pulses;
        a_kick();
        a_run(200, n, busy1);
        n_cmp++;
        if (n != 57 || busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reload_latency: got %0d busy %b want 57 1", n, busy1);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (a_rises - r0 != 26 || a_bits[25:0] !== exp_bits || a_load_pulses - lp0 != 1) begin
            n_err++;
            $display("FAIL mid_reload_content: rises %0d bits %b loads %0d want 26 %b 1",
                     a_rises - r0, a_bits[25:0], a_load_pulses - lp0, exp_bits);
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        logic busy1, saw_busy;
        a_kick();
        a_run(200, n, busy1);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (a_busy !== 1'b0) saw_busy = 1'b1;
        end
        n_cmp++;
        if (saw_busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_start_with_done_dropped: busy seen %b want 0", saw_busy);
        end
        a_kick();
        a_run(200, n, busy1);
        @(posedge clk); #1;
        n_cmp++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_after_done: done %b busy %b want 0 0", a_done, a_busy);
        end
        a_kick();
        a_run(200, n, busy1);
        n_cmp++;
        if (n != 57 || busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_start_after_done: latency %0d busy %b want 57 1", n, busy1);
        end
    endtask

    task automatic test_full_chain();
        int   r0, lp0, lc0, n;
        logic busy1;
        r0 = b_rises; lp0 = b_load_pulses; lc0 = b_load_cycles;
        b_kick();
        b_run_load(4000, n, busy1);
        n_cmp++;
        if (n != 3009 || busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL full_done_latency: got %0d busy %b want 3009 1", n, busy1);
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (b_rises - r0 != 494) begin
            n_err++;
            $display("FAIL full_rise_count: got %0d want 494", b_rises - r0);
        end
        n_cmp++;
        if (b_zero_bits != 0) begin
            n_err++;
            $display("FAIL full_all_ones: got %0d zero bits want 0", b_zero_bits);
        end
        n_cmp++;
        if (b_hi_min != 3 || b_hi_max != 3 || b_lo_min != 3) begin
            n_err++;
            $display("FAIL full_sclk_widths: hi %0d..%0d lo min %0d want 3..3 3",
                     b_hi_min, b_hi_max, b_lo_min);
        end
        n_cmp++;
        if (b_load_pulses - lp0 != 1 || b_load_cycles - lc0 != 3) begin
            n_err++;
            $display("FAIL full_latch_pulse: pulses %0d cycles %0d want 1 3",
                     b_load_pulses - lp0, b_load_cycles - lc0);
        end
        n_cmp++;
        if (b_busy !== 1'b0 || b_idx !== 6'd0) begin
            n_err++;
            $display("FAIL full_idle_after: busy %b idx %0d want 0 0", b_busy, b_idx);
        end
    endtask

    initial begin
        a_mem[1]  = cfg_word(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        a_mem[0]  = cfg_word(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        b_rd_data = cfg_word(3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        test_reset();
        test_load();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_full_chain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
